alu_packet_engine: RTL and testbench
====================================

# alu_packet_engine

Synthesizable byte-stream ALU sitting between `uart_rx` and `uart_tx` on the icebreaker top, in the 60 MHz PLL domain. Parses length-prefixed packets from the receive stream, executes ECHO, ADD or MUL over a configurable word width, and streams the result bytes back. Malformed, unknown or stalled packets are flagged and recovered from without a reset.

## Interface
- `WORD_BYTES`, 4: operand/result width in bytes; result width `WORD_W = 8*WORD_BYTES`.
- `LEN_W`, 16: packet length field width; must be 16 in this revision.
- `TIMEOUT_CYCLES`, 600000: idle cycles allowed between bytes inside a packet (10 ms at 60 MHz); ≥2.
- `clk_i`  in  1  single clock; all logic rising-edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `rx_data_i`  in  8  byte from `uart_rx`.
- `rx_valid_i`  in  1  `rx_data_i` valid.
- `rx_ready_o`  out  1  engine accepts byte this cycle.
- `tx_data_o`  out  8  byte to `uart_tx`.
- `tx_valid_o`  out  1  `tx_data_o` valid.
- `tx_ready_i`  in  1  `uart_tx` accepts byte.
- `busy_o`  out  1  high in any state except `S_OPCODE`.
- `err_o`  out  1  one-cycle pulse on any error or timeout.

## Operation
- Packet: `[opcode][0x00 reserved][len_lo][len_hi][payload]`. `len` = total bytes including 4-byte header; payload = `len-4` bytes. Reserved byte is ignored.
- Opcodes: `0xEC` ECHO (payload returned byte-for-byte); `0xAD` ADD (sum of payload words mod 2^WORD_W); `0x88` MUL (low WORD_W bits of product; signed and unsigned results are identical).
- Words are little-endian, WORD_BYTES each. The result is sent as WORD_BYTES little-endian bytes. Zero operands: ADD→0, MUL→1.
- States: `S_OPCODE`→`S_RSVD`→`S_LEN_LO`→`S_LEN_HI`→one of `S_ECHO`, `S_OPERAND`, `S_DRAIN`, `S_RESULT`, `S_ERR`→`S_OPCODE`.
- At `S_LEN_HI` accept:
  - `len<4` → `S_ERR`.
  - `len==4`: ECHO → `S_OPCODE`; ADD/MUL → `S_RESULT`.
  - Otherwise:
    - ECHO → `S_ECHO`.
    - ADD/MUL with `(len-4) % WORD_BYTES==0` → `S_OPERAND`.
    - Unknown opcode, or ADD/MUL with a bad length → `S_DRAIN`.
- `S_DRAIN` discards `len-4` bytes, then `S_ERR`. `S_ERR` sends one byte `0xEE`, pulses `err_o`, then goes to `S_OPCODE`.
- Accumulator: loaded with identity (0 or 1) at header end. After each full word, updated at the following edge: `acc <= acc + w` or `acc <= acc * w`, truncated to WORD_W. The word register is shifted in LSB-first by byte.
- Timeout:
  - Counter clears on every accepted byte and whenever `rx_ready_o` is low.
  - It counts in `S_RSVD`, `S_LEN_*`, `S_ECHO`, `S_OPERAND` and `S_DRAIN`.
  - On reaching TIMEOUT_CYCLES: pulse `err_o`, flush tx, go to `S_OPCODE`, send nothing.
- Reset values: `rx_ready_o`=0, `tx_valid_o`=0, `tx_data_o`=0, `busy_o`=0, `err_o`=0, state `S_OPCODE`, accumulator 0.

## Timing
- Handshakes are AXI-stream rules. A transfer occurs when valid && ready on a rising edge. `tx_valid_o` stays high and `tx_data_o` stays stable until `tx_ready_i`. `tx_valid_o` never depends combinationally on `tx_ready_i`.
- `rx_ready_o`:
  - 1 in header, operand and drain states.
  - In `S_ECHO`: `!tx_valid_o || tx_ready_i`, i.e. a single output register with simultaneous drain and refill.
  - 0 in `S_RESULT` and `S_ERR`.
- ECHO latency: byte accepted at edge N → `tx_valid_o` high from edge N.
- ADD/MUL: last operand byte at edge N → accumulate at N+1 → first result byte valid after edge N+2. WORD_BYTES bytes follow back-to-back if `tx_ready_i` is held high.
- `err_o` asserts in the same cycle that `0xEE` is first presented, or on the timeout cycle.
- Asserting `rst_ni` at any point immediately drops `tx_valid_o` and abandons the packet.

## Structure
- `alu_pkg`: opcode enum (`OP_ECHO`, `OP_ADD`, `OP_MUL`), state enum, `HDR_BYTES=4`, `ERR_BYTE=8'hEE`.
- Sub-module `alu_word_serializer`: loads a WORD_W word and emits it LSB byte first under the tx handshake, reporting `done`. Instantiated once in `alu_packet_engine`.

## Test plan
- ADD: `AD 00 0C 00 05 00 00 00 07 00 00 00` → `0C 00 00 00`, `err_o` never high.
- ADD wrap: operands `FFFFFFFF`, `00000002` → `01 00 00 00`. MUL: `03000000`×`FFFFFFFF` (LE bytes `03 00 00 00`, `FF FF FF FF`) → `FD FF FF FF`.
- ECHO with `tx_ready_i` toggling every cycle: `EC 00 07 00 41 42 43` → `41 42 43` in order, none dropped or duplicated.
- Unknown opcode `55 00 06 00 AA BB` → exactly one `EE` and one `err_o` pulse. A following `AD 00 04 00` → `00 00 00 00`.
- Timeout: `AD 00 0C 00 05`, then silence for TIMEOUT_CYCLES (shortened to 100 for sim) → `err_o` pulse, no tx bytes. The next valid packet is processed correctly.
- Reset asserted mid-result after 2 of 4 bytes → `tx_valid_o` low immediately, no further bytes. A new packet after release works normally.

Source files
------------

// File: rtl/alu_packet_engine_pkg.sv
// Shared types and constants for the byte-stream ALU packet engine.
package alu_pkg;
    localparam int         HDR_BYTES = 4;
    localparam logic [7:0] ERR_BYTE  = 8'hEE;

    typedef enum logic [7:0] {
        OP_ECHO = 8'hEC,
        OP_ADD  = 8'hAD,
        OP_MUL  = 8'h88
    } opcode_e;

    typedef enum logic [3:0] {
        S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI,
        S_ECHO, S_OPERAND, S_DRAIN, S_RESULT, S_ERR
    } state_e;

    function automatic logic is_arith(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction
endpackage

// File: rtl/alu_packet_engine_if.sv
// Receive/transmit byte streams plus status flags of the packet engine.
interface alu_packet_engine_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       err_o;

    modport slave  (input  rx_data_i, rx_valid_i, tx_ready_i,
                    output rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o);
    modport master (output rx_data_i, rx_valid_i, tx_ready_i,
                    input  rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o);
endinterface

// File: rtl/alu_packet_engine_serializer.sv
// Emits a loaded word LSB byte first over a valid/ready stream.
module alu_word_serializer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    i_load,
    input  logic [8*WORD_BYTES-1:0] i_word,
    input  logic                    i_ready,
    output logic [7:0]              o_data,
    output logic                    o_valid,
    output logic                    o_done
);
    localparam int CNT_W = $clog2(WORD_BYTES + 1);

    logic [8*WORD_BYTES-1:0] r_word;
    logic [CNT_W-1:0]        r_left;
    logic                    r_valid;

    assign o_data  = r_word[7:0];
    assign o_valid = r_valid;
    assign o_done  = r_valid && i_ready && (r_left == CNT_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word  <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_left  <= CNT_W'(WORD_BYTES);
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_word <= r_word >> 8;
            r_left <= r_left - 1'b1;
            if (r_left == CNT_W'(1)) r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_packet_engine.sv
// Parses length-prefixed packets, runs ECHO/ADD/MUL and streams results back.
module alu_packet_engine
    import alu_pkg::*;
#(
    parameter int WORD_BYTES     = 4,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    alu_packet_engine_if.slave  bus
);
    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    state_e             r_state, w_next;
    logic               r_run, r_pend, r_txv, r_ee, r_err;
    logic [7:0]         r_op, r_len_lo, r_txd;
    logic [LEN_W-1:0]   r_cnt;
    logic [WORD_W-1:0]  r_word, r_acc;
    logic [BC_W-1:0]    r_bcnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               w_rx_ready, w_acc, w_last, w_tmo_en, w_tmo;
    logic               w_ser_load, w_ser_valid, w_ser_done;
    logic [7:0]         w_ser_data;
    logic [LEN_W-1:0]   w_len, w_pay;

    assign w_len    = LEN_W'({bus.rx_data_i, r_len_lo});
    assign w_pay    = w_len - LEN_W'(HDR_BYTES);
    assign w_acc    = bus.rx_valid_i && w_rx_ready;
    assign w_last   = (r_cnt == LEN_W'(1));
    assign w_tmo_en = (r_state inside {S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPERAND, S_DRAIN})
                      && w_rx_ready && !w_acc;
    assign w_tmo    = w_tmo_en && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    // Result starts only once the final word is folded in and any echo/error byte has left.
    assign w_ser_load = (r_state == S_RESULT) && !r_pend && !w_ser_valid && !r_txv;

    assign bus.rx_ready_o = w_rx_ready;
    assign bus.tx_valid_o = r_txv | w_ser_valid;
    assign bus.tx_data_o  = w_ser_valid ? w_ser_data : r_txd;
    assign bus.busy_o     = (r_state != S_OPCODE);
    assign bus.err_o      = r_err;

    always_comb begin
        w_rx_ready = 1'b0;
        if (r_run) begin
            case (r_state)
                S_ECHO:          w_rx_ready = !r_txv || bus.tx_ready_i;
                S_RESULT, S_ERR: w_rx_ready = 1'b0;
                default:         w_rx_ready = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_tmo) begin
            w_next = S_OPCODE;
        end else begin
            case (r_state)
                S_OPCODE: if (w_acc) w_next = S_RSVD;
                S_RSVD:   if (w_acc) w_next = S_LEN_LO;
                S_LEN_LO: if (w_acc) w_next = S_LEN_HI;
                S_LEN_HI: if (w_acc) begin
                    if (w_len < LEN_W'(HDR_BYTES))       w_next = S_ERR;
                    else if (w_len == LEN_W'(HDR_BYTES)) begin
                        if (r_op == OP_ECHO)             w_next = S_OPCODE;
                        else if (is_arith(r_op))         w_next = S_RESULT;
                        else                             w_next = S_ERR;
                    end
                    else if (r_op == OP_ECHO)            w_next = S_ECHO;
                    else if (is_arith(r_op) && (w_pay % LEN_W'(WORD_BYTES)) == '0)
                                                         w_next = S_OPERAND;
                    else                                 w_next = S_DRAIN;
                end
                S_ECHO:    if (w_acc && w_last) w_next = S_OPCODE;
                S_OPERAND: if (w_acc && w_last) w_next = S_RESULT;
                S_DRAIN:   if (w_acc && w_last) w_next = S_ERR;
                S_RESULT:  if (w_ser_done) w_next = S_OPCODE;
                S_ERR:     if (r_ee && r_txv && bus.tx_ready_i) w_next = S_OPCODE;
                default:   w_next = S_OPCODE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_OPCODE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run <= 1'b0;  r_pend <= 1'b0;  r_txv <= 1'b0;  r_ee <= 1'b0;  r_err <= 1'b0;
            r_op  <= '0;    r_len_lo <= '0;  r_txd <= '0;    r_cnt <= '0;
            r_word <= '0;   r_acc <= '0;     r_bcnt <= '0;   r_tmo <= '0;
        end else begin
            r_run <= 1'b1;
            r_err <= 1'b0;
            if (r_txv && bus.tx_ready_i) r_txv <= 1'b0;
            r_tmo <= (w_tmo_en && !w_tmo) ? r_tmo + 1'b1 : '0;
            if (r_pend) begin
                r_acc  <= (r_op == OP_MUL) ? r_acc * r_word : r_acc + r_word;
                r_pend <= 1'b0;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
                r_txv <= 1'b0;
            end else begin
                case (r_state)
                    S_OPCODE: if (w_acc) r_op <= bus.rx_data_i;
                    S_LEN_LO: if (w_acc) r_len_lo <= bus.rx_data_i;
                    S_LEN_HI: if (w_acc) begin
                        r_cnt  <= w_pay;
                        r_bcnt <= '0;
                        r_acc  <= (r_op == OP_MUL) ? WORD_W'(1) : '0;
                    end
                    S_ECHO: if (w_acc) begin
                        r_txv <= 1'b1;
                        r_txd <= bus.rx_data_i;
                        r_cnt <= r_cnt - 1'b1;
                    end
                    S_OPERAND: if (w_acc) begin
                        r_word <= {bus.rx_data_i, r_word[WORD_W-1:8]};
                        r_cnt  <= r_cnt - 1'b1;
                        if (r_bcnt == BC_W'(WORD_BYTES - 1)) begin
                            r_bcnt <= '0;
                            r_pend <= 1'b1;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                    S_DRAIN: if (w_acc) r_cnt <= r_cnt - 1'b1;
                    S_ERR: begin
                        if (!r_ee && !r_txv) begin
                            r_txv <= 1'b1;
                            r_txd <= ERR_BYTE;
                            r_err <= 1'b1;
                            r_ee  <= 1'b1;
                        end else if (r_ee && r_txv && bus.tx_ready_i) begin
                            r_ee <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    alu_word_serializer #(.WORD_BYTES(WORD_BYTES)) u_ser (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_load  (w_ser_load),
        .i_word  (r_acc),
        .i_ready (bus.tx_ready_i),
        .o_data  (w_ser_data),
        .o_valid (w_ser_valid),
        .o_done  (w_ser_done)
    );
endmodule

// File: tb/tb_alu_packet_engine.sv
// Directed bench for alu_packet_engine: arithmetic, echo, errors, timeout, reset.
module tb_alu_packet_engine;
    logic clk, rst_n;
    logic rdy, toggle, tog;
    int   npass, ntotal, nfail, errcnt;
    logic [7:0] txq[$];
    logic [7:0] pkt[$];

    alu_packet_engine_if bus();

    alu_packet_engine #(.WORD_BYTES(4), .LEN_W(16), .TIMEOUT_CYCLES(100)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    assign bus.tx_ready_i = toggle ? tog : rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) tog = ~tog;

    always @(posedge clk) begin
        if (rst_n && bus.tx_valid_o && bus.tx_ready_i) txq.push_back(bus.tx_data_o);
        if (bus.err_o) errcnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        #1;
        while (!bus.rx_ready_o && n < 1000) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 1000) check("rx_accept_bound", 32'(n), 32'(0));
        @(posedge clk); #1;
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic wait_tx(input string tag, input int n);
        int k = 0;
        while (txq.size() < n && k < 300) begin
            @(negedge clk); k++;
        end
        repeat (6) @(negedge clk);
        check(tag, 32'(txq.size()), 32'(n));
    endtask

    task automatic check_word(input string tag, input int base, input logic [31:0] exp);
        logic [31:0] got;
        got = {txq[base+3], txq[base+2], txq[base+1], txq[base]};
        check(tag, got, exp);
    endtask

    initial begin
        int b, e0;
        npass = 0; ntotal = 0; nfail = 0; errcnt = 0;
        rst_n = 1'b0; rdy = 1'b1; toggle = 1'b0; tog = 1'b0;
        bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(bus.rx_ready_o), 0);
        check("rst_tx_valid", 32'(bus.tx_valid_o), 0);
        check("rst_tx_data",  32'(bus.tx_data_o),  0);
        check("rst_busy",     32'(bus.busy_o),     0);
        check("rst_err",      32'(bus.err_o),      0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rx_ready", 32'(bus.rx_ready_o), 1);

        // ADD 5 + 7 with latency check on the first result byte
        pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00};
        send_pkt();
        check("add_busy", 32'(bus.busy_o), 1);
        send_byte(8'h00);
        @(negedge clk); check("add_lat_n0", 32'(bus.tx_valid_o), 0);
        @(negedge clk); check("add_lat_n1", 32'(bus.tx_valid_o), 0);
        @(negedge clk); check("add_lat_n2", 32'(bus.tx_valid_o), 1);
        check("add_first_byte", 32'(bus.tx_data_o), 32'h0C);
        wait_tx("add_count", 4);
        check_word("add_result", 0, 32'h0000000C);
        check("add_no_err", 32'(errcnt), 0);

        b = txq.size();
        pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_tx("addwrap_count", b + 4);
        check_word("addwrap_result", b, 32'h00000001);

        b = txq.size();
        pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_pkt();
        wait_tx("mul_count", b + 4);
        check_word("mul_result", b, 32'hFFFFFFFD);

        // ECHO with back-pressure toggling every cycle
        b = txq.size();
        toggle = 1'b1;
        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        send_pkt();
        wait_tx("echo_count", b + 3);
        toggle = 1'b0;
        check("echo_b0", 32'(txq[b]),   32'h41);
        check("echo_b1", 32'(txq[b+1]), 32'h42);
        check("echo_b2", 32'(txq[b+2]), 32'h43);

        // unknown opcode, then zero-operand ADD and MUL
        b = txq.size(); e0 = errcnt;
        pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt();
        wait_tx("unk_count", b + 1);
        check("unk_byte", 32'(txq[b]), 32'hEE);
        check("unk_err_pulses", 32'(errcnt), 32'(e0 + 1));

        b = txq.size();
        pkt = '{8'hAD, 8'h00, 8'h04, 8'h00};
        send_pkt();
        wait_tx("add0_count", b + 4);
        check_word("add0_result", b, 32'h00000000);

        b = txq.size();
        pkt = '{8'h88, 8'h00, 8'h04, 8'h00};
        send_pkt();
        wait_tx("mul0_count", b + 4);
        check_word("mul0_result", b, 32'h00000001);

        // ADD with payload not a multiple of the word size
        b = txq.size(); e0 = errcnt;
        pkt = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
        send_pkt();
        wait_tx("badlen_count", b + 1);
        check("badlen_byte", 32'(txq[b]), 32'hEE);
        check("badlen_err", 32'(errcnt), 32'(e0 + 1));

        // length shorter than the header
        b = txq.size(); e0 = errcnt;
        pkt = '{8'hAD, 8'h00, 8'h02, 8'h00};
        send_pkt();
        wait_tx("short_count", b + 1);
        check("short_byte", 32'(txq[b]), 32'hEE);
        check("short_err", 32'(errcnt), 32'(e0 + 1));

        // timeout inside an operand
        b = txq.size(); e0 = errcnt;
        pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05};
        send_pkt();
        repeat (90) @(negedge clk);
        check("tmo_not_early", 32'(errcnt), 32'(e0));
        repeat (30) @(negedge clk);
        check("tmo_err", 32'(errcnt), 32'(e0 + 1));
        check("tmo_no_tx", 32'(txq.size()), 32'(b));
        check("tmo_idle", 32'(bus.busy_o), 0);
        pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_tx("tmo_next_count", b + 4);
        check_word("tmo_next_result", b, 32'h0000000C);

        // reset in the middle of a result
        b = txq.size(); e0 = errcnt;
        send_pkt();
        begin
            int k = 0;
            while (txq.size() < b + 2 && k < 200) begin @(negedge clk); k++; end
        end
        check("rstmid_two_sent", 32'(txq.size()), 32'(b + 2));
        rst_n = 1'b0;
        #1;
        check("rstmid_valid_drop", 32'(bus.tx_valid_o), 0);
        repeat (5) @(negedge clk);
        check("rstmid_no_more", 32'(txq.size()), 32'(b + 2));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        b = txq.size();
        send_pkt();
        wait_tx("rstmid_next_count", b + 4);
        check_word("rstmid_next_result", b, 32'h0000000C);
        check("rstmid_no_err", 32'(errcnt), 32'(e0));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
